// File: rtl/rob.sv
// In-order reorder buffer: 4-lane allocate, 3 writeback ports, up to 3 oldest-first retires per cycle.
// Optional ROB_WB_BYPASS_EN: same-cycle writebacks on head..head+2 count as done and forward their data.
module rob (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  i_alloc_valid,
    input  logic [11:0] i_alloc_dest,
    output logic        o_alloc_ready,
    output logic [23:0] o_alloc_tag,
    input  logic [2:0]  i_wb_valid,
    input  logic [17:0] i_wb_tag,
    input  logic [47:0] i_wb_data,
    input  logic        i_flush,
    output logic [2:0]  o_commit_wen,
    output logic [8:0]  o_commit_waddr,
    output logic [47:0] o_commit_wdata,
    output logic [17:0] o_commit_tag,
    output logic [6:0]  o_count,
    output logic        o_empty,
    output logic        o_full
);
    localparam int DEPTH = 64;
    localparam int TW    = 6;

    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_done;
    logic [2:0]       r_dest [DEPTH];
    logic [15:0]      r_data [DEPTH];
    logic [TW-1:0]    r_head;
    logic [TW-1:0]    r_tail;
    logic [6:0]       r_count;
    logic [2:0]       r_commit_wen;
    logic [8:0]       r_commit_waddr;
    logic [47:0]      r_commit_wdata;
    logic [17:0]      r_commit_tag;

    logic [2:0]       w_alloc_off [5];
    logic [TW-1:0]    w_alloc_idx [4];
    logic             w_alloc_go;
    logic [2:0]       w_nalloc;
    logic [TW-1:0]    w_cidx [3];
    logic [2:0]       w_cdone;
    logic [15:0]      w_cdata [3];
    logic [1:0]       w_k;

    assign o_alloc_ready = (r_count <= 7'(DEPTH - 4));
    assign w_alloc_go    = o_alloc_ready & ~i_flush;
    assign w_alloc_off[0] = 3'd0;

    // Valid lanes are packed onto consecutive tags starting at tail.
    for (genvar gi = 0; gi < 4; gi++) begin : g_alloc
        assign w_alloc_off[gi+1]       = w_alloc_off[gi] + {2'b00, i_alloc_valid[gi]};
        assign w_alloc_idx[gi]         = r_tail + TW'(w_alloc_off[gi]);
        assign o_alloc_tag[gi*TW +: TW] = w_alloc_idx[gi];
    end
    assign w_nalloc = w_alloc_go ? w_alloc_off[4] : 3'd0;

    for (genvar gi = 0; gi < 3; gi++) begin : g_cidx
        assign w_cidx[gi] = r_head + TW'(gi);
    end

    always_comb begin
        for (int j = 0; j < 3; j++) begin
            w_cdone[j] = r_valid[w_cidx[j]] & r_done[w_cidx[j]];
            w_cdata[j] = r_data[w_cidx[j]];
`ifdef ROB_WB_BYPASS_EN
            for (int p = 0; p < 3; p++) begin
                if (i_wb_valid[p] && (i_wb_tag[p*TW +: TW] == w_cidx[j]) && r_valid[w_cidx[j]]) begin
                    w_cdone[j] = 1'b1;
                    w_cdata[j] = i_wb_data[p*16 +: 16];
                end
            end
`endif
        end
    end

    // Retire run stops at the first not-done entry to keep retirement in order.
    assign w_k = !w_cdone[0] ? 2'd0 : !w_cdone[1] ? 2'd1 : !w_cdone[2] ? 2'd2 : 2'd3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid        <= '0;
            r_done         <= '0;
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            r_commit_wen   <= '0;
            r_commit_waddr <= '0;
            r_commit_wdata <= '0;
            r_commit_tag   <= '0;
        end else if (i_flush) begin
            r_valid        <= '0;
            r_done         <= '0;
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            r_commit_wen   <= '0;
            r_commit_waddr <= '0;
            r_commit_wdata <= '0;
            r_commit_tag   <= '0;
        end else begin
            for (int p = 0; p < 3; p++) begin
                if (i_wb_valid[p] && r_valid[i_wb_tag[p*TW +: TW]]) begin
                    r_done[i_wb_tag[p*TW +: TW]] <= 1'b1;
                end
            end
            for (int j = 0; j < 3; j++) begin
                if (2'(j) < w_k) begin
                    r_valid[w_cidx[j]]       <= 1'b0;
                    r_done[w_cidx[j]]        <= 1'b0;
                    r_commit_wen[j]          <= 1'b1;
                    r_commit_waddr[j*3 +: 3] <= r_dest[w_cidx[j]];
                    r_commit_wdata[j*16 +: 16] <= w_cdata[j];
                    r_commit_tag[j*TW +: TW] <= w_cidx[j];
                end else begin
                    r_commit_wen[j]          <= 1'b0;
                    r_commit_waddr[j*3 +: 3] <= 3'd0;
                    r_commit_wdata[j*16 +: 16] <= 16'd0;
                    r_commit_tag[j*TW +: TW] <= '0;
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (w_alloc_go && i_alloc_valid[i]) begin
                    r_valid[w_alloc_idx[i]] <= 1'b1;
                    r_done[w_alloc_idx[i]]  <= 1'b0;
                end
            end
            r_head  <= r_head + TW'(w_k);
            r_tail  <= r_tail + TW'(w_nalloc);
            r_count <= r_count + 7'(w_nalloc) - 7'(w_k);
        end
    end

    // Payload storage carries no reset; validity is tracked by r_valid alone.
    always_ff @(posedge clk) begin
        if (!i_flush) begin
            for (int p = 0; p < 3; p++) begin
                if (i_wb_valid[p] && r_valid[i_wb_tag[p*TW +: TW]]) begin
                    r_data[i_wb_tag[p*TW +: TW]] <= i_wb_data[p*16 +: 16];
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (w_alloc_go && i_alloc_valid[i]) begin
                    r_dest[w_alloc_idx[i]] <= i_alloc_dest[i*3 +: 3];
                end
            end
        end
    end

    assign o_commit_wen   = r_commit_wen;
    assign o_commit_waddr = r_commit_waddr;
    assign o_commit_wdata = r_commit_wdata;
    assign o_commit_tag   = r_commit_tag;
    assign o_count        = r_count;
    assign o_empty        = (r_count == 7'd0);
    assign o_full         = (r_count == 7'(DEPTH));
endmodule

// File: tb/tb_rob.sv
// Directed bench for rob: expected retirements are queued at writeback and popped as commit ports fire.
module tb_rob;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  alloc_valid;
    logic [11:0] alloc_dest;
    logic        alloc_ready;
    logic [23:0] alloc_tag;
    logic [2:0]  wb_valid;
    logic [17:0] wb_tag;
    logic [47:0] wb_data;
    logic        flush;
    logic [2:0]  commit_wen;
    logic [8:0]  commit_waddr;
    logic [47:0] commit_wdata;
    logic [17:0] commit_tag;
    logic [6:0]  count;
    logic        empty;
    logic        full;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    logic [24:0] sb_q [$];
    logic [2:0]  exp_dest [64];
    logic [5:0]  tb_tail = 6'd0;

    rob dut (
        .clk            (clk),
        .rst            (rst),
        .i_alloc_valid  (alloc_valid),
        .i_alloc_dest   (alloc_dest),
        .o_alloc_ready  (alloc_ready),
        .o_alloc_tag    (alloc_tag),
        .i_wb_valid     (wb_valid),
        .i_wb_tag       (wb_tag),
        .i_wb_data      (wb_data),
        .i_flush        (flush),
        .o_commit_wen   (commit_wen),
        .o_commit_waddr (commit_waddr),
        .o_commit_wdata (commit_wdata),
        .o_commit_tag   (commit_tag),
        .o_count        (count),
        .o_empty        (empty),
        .o_full         (full)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] tags(input logic [5:0] a, input logic [5:0] b,
                                         input logic [5:0] c, input logic [5:0] d);
        return {d, c, b, a};
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    task automatic clear();
        alloc_valid = 4'd0;
        wb_valid    = 3'd0;
        wb_tag      = 18'd0;
        wb_data     = 48'd0;
        flush       = 1'b0;
    endtask

    task automatic alloc(input logic [3:0] m, input logic [11:0] d, input bit accept);
        logic [5:0] t;
        t = tb_tail;
        alloc_valid = m;
        alloc_dest  = d;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) begin
                if (accept) exp_dest[t] = d[3*i +: 3];
                t = t + 6'd1;
            end
        end
        if (accept) tb_tail = t;
    endtask

    task automatic wb(input int p, input logic [5:0] t, input logic [15:0] v, input bit push);
        wb_valid[p]        = 1'b1;
        wb_tag[6*p +: 6]   = t;
        wb_data[16*p +: 16] = v;
        if (push) sb_q.push_back({t, exp_dest[t], v});
    endtask

    // One clock edge, then every asserted commit port is matched against the scoreboard.
    task automatic step();
        logic [24:0] e;
        @(posedge clk);
        #1;
        for (int j = 0; j < 3; j++) begin
            if (commit_wen[j] === 1'b1) begin
                if (sb_q.size() > 0) e = sb_q.pop_front();
                else e = 25'bx;
                chk($sformatf("commit_port%0d", j),
                    32'({commit_tag[6*j +: 6], commit_waddr[3*j +: 3], commit_wdata[16*j +: 16]}),
                    32'(e));
            end
        end
    endtask

    initial begin
        clear();
        alloc_dest = 12'd0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full",  32'(full),  32'd0);
        chk("rst_ready", 32'(alloc_ready), 32'd1);
        chk("rst_wen",   32'(commit_wen), 32'd0);

        alloc(4'b1111, {3'd4, 3'd3, 3'd2, 3'd1}, 1'b1);
        #1;
        chk("t1_alloc_tag", 32'(alloc_tag), 32'(tags(6'd0, 6'd1, 6'd2, 6'd3)));
        step(); clear();
        chk("t1_count", 32'(count), 32'd4);
        chk("t1_wen",   32'(commit_wen), 32'd0);

        wb(0, 6'd0, 16'h1111, 1'b1);
        wb(1, 6'd1, 16'h2222, 1'b1);
        wb(2, 6'd2, 16'h3333, 1'b1);
        step(); clear();
        chk("t2_wen_latency", 32'(commit_wen), 32'd0);
        step();
        chk("t2_wen",   32'(commit_wen), 32'b111);
        chk("t2_count", 32'(count), 32'd1);

        alloc(4'b1010, {3'd6, 3'd0, 3'd5, 3'd0}, 1'b1);
        #1;
        chk("t3_alloc_compact", 32'(alloc_tag), 32'(tags(6'd4, 6'd4, 6'd5, 6'd5)));
        step(); clear();
        chk("t3_count", 32'(count), 32'd3);
        wb(0, 6'd4, 16'h4444, 1'b0);
        step(); clear();
        step();
        chk("t3_blocked_a", 32'(commit_wen), 32'd0);
        step();
        chk("t3_blocked_b", 32'(commit_wen), 32'd0);
        wb(2, 6'd3, 16'h3030, 1'b1);
        sb_q.push_back({6'd4, exp_dest[4], 16'h4444});
        wb(0, 6'd5, 16'h5555, 1'b1);
        step(); clear();
        step();
        chk("t3_wen",   32'(commit_wen), 32'b111);
        chk("t3_empty", 32'(empty), 32'd1);

        for (int i = 0; i < 15; i++) begin
            alloc(4'b1111, {3'd3, 3'd2, 3'd1, 3'd0}, 1'b1);
            step();
        end
        clear();
        chk("t4_count60", 32'(count), 32'd60);
        chk("t4_ready60", 32'(alloc_ready), 32'd1);
        alloc(4'b0001, 12'd0, 1'b1);
        step(); clear();
        chk("t4_count61", 32'(count), 32'd61);
        chk("t4_ready61", 32'(alloc_ready), 32'd0);
        chk("t4_full61",  32'(full), 32'd0);
        alloc(4'b1111, {3'd3, 3'd2, 3'd1, 3'd0}, 1'b0);
        step(); clear();
        #1;
        chk("t4_drop_count", 32'(count), 32'd61);
        chk("t4_drop_tail",  32'(alloc_tag), 32'(tags(6'd3, 6'd3, 6'd3, 6'd3)));
        wb(0, 6'd6, 16'h0606, 1'b1);
        step(); clear();
        alloc(4'b1111, {3'd3, 3'd2, 3'd1, 3'd0}, 1'b0);
        step(); clear();
        chk("t4_retire_wen",   32'(commit_wen), 32'b001);
        chk("t4_retire_count", 32'(count), 32'd60);
        chk("t4_ready_again",  32'(alloc_ready), 32'd1);
        alloc(4'b1111, {3'd3, 3'd2, 3'd1, 3'd0}, 1'b1);
        step(); clear();
        chk("t4_full",      32'(full), 32'd1);
        chk("t4_count64",   32'(count), 32'd64);
        chk("t4_ready_full", 32'(alloc_ready), 32'd0);

        for (int t = 7; t <= 61; t += 3) begin
            for (int p = 0; p < 3; p++) begin
                if (t + p <= 61) wb(p, 6'(t + p), 16'((t + p) * 257), 1'b1);
            end
            step(); clear();
        end
        step();
        chk("t5_count_drained", 32'(count), 32'd9);

        wb(0, 6'd62, 16'h6262, 1'b1);
        wb(1, 6'd63, 16'h6363, 1'b1);
        wb(2, 6'd0,  16'h0a0a, 1'b1);
        step(); clear();
        step();
        chk("t5_wrap_wen",  32'(commit_wen), 32'b111);
        chk("t5_wrap_tags", 32'(commit_tag), 32'({6'd0, 6'd63, 6'd62}));
        chk("t5_count",     32'(count), 32'd6);

        wb(0, 6'd1, 16'hAAAA, 1'b0);
        wb(1, 6'd1, 16'hBBBB, 1'b1);
        wb(2, 6'd2, 16'h2222, 1'b1);
        step(); clear();
        step();
        chk("hiport_wen",   32'(commit_wen), 32'b011);
        chk("hiport_count", 32'(count), 32'd4);

        wb(0, 6'd3, 16'h0303, 1'b0);
        step(); clear();
        alloc(4'b1111, {3'd3, 3'd2, 3'd1, 3'd0}, 1'b0);
        wb(1, 6'd4, 16'h0404, 1'b0);
        flush = 1'b1;
        step(); clear();
        chk("t6_count", 32'(count), 32'd0);
        chk("t6_empty", 32'(empty), 32'd1);
        chk("t6_wen",   32'(commit_wen), 32'd0);
        tb_tail = 6'd0;
        alloc(4'b0001, 12'd7, 1'b1);
        #1;
        chk("t6_tag_a", 32'(alloc_tag[5:0]), 32'd0);
        step(); clear();
        step();
        chk("t6_flush_no_commit", 32'(commit_wen), 32'd0);
        alloc(4'b0001, 12'd6, 1'b1);
        step(); clear();
        wb(0, 6'd0, 16'h0700, 1'b1);
        step(); clear();
        step();
        chk("t6_wen_one", 32'(commit_wen), 32'b001);
        step();
        chk("t6_pending_wen",   32'(commit_wen), 32'd0);
        chk("t6_pending_count", 32'(count), 32'd1);
        wb(0, 6'd1, 16'h0601, 1'b1);
        step(); clear();
        step();
        chk("t6_drain_count", 32'(count), 32'd0);

        alloc(4'b0001, 12'd5, 1'b1);
        step(); clear();
        wb(0, 6'd2, 16'h5151, 1'b1);
        step(); clear();
        step();
        chk("arst_pre_wen", 32'(commit_wen), 32'b001);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_wen",   32'(commit_wen), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        rst = 1'b0;

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
